joystick_protocols_mp: RTL and testbench
========================================

Name: joystick_protocols_mp

Overview:
- Multi-channel successor to the joystick protocol block.
- Maps one keyboard-emulated joystick plus NUM_SLOTS DB9 logical joysticks, time-multiplexed from one physical DB9 port through a hardware splitter, onto Kempston, Fuller, Sinclair P1/P2, Cursor and OPQA/SPACE/M protocols.
- Each channel has its own config register and programmable autofire rate.
- Sits between the ZXUNO register bank, the CPU I/O read mux and the keyboard column path.

Parameters:
- NUM_SLOTS, 2: DB9 logical joysticks behind the splitter (1..4); total channels NCH = NUM_SLOTS+1 (ch0 = keyboard joystick).
- SLOT_CYCLES, 140000: clk cycles per splitter slot (200 Hz at 28 MHz).
- SETTLE_CYCLES, 64: cycles after select change before sampling; must be less than SLOT_CYCLES.
- JOYCONF_BASE, 8'h06: ZXUNO address of ch0 config; ch n at JOYCONF_BASE+n.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- a  in  16  CPU address
- iorq_n  in  1  CPU IORQ, active-low
- rd_n  in  1  CPU RD, active-low
- din  in  8  CPU data for register writes
- dout  out  8  read data
- oe  out  1  read data valid
- zxuno_addr  in  8  ZXUNO register address
- zxuno_regrd  in  1  ZXUNO register read strobe
- zxuno_regwr  in  1  ZXUNO register write strobe
- kbdjoy_in  in  5  keyboard joystick state: FUDLR, 1 = pressed
- db9_in  in  6  physical DB9: F2 F1 U D L R, 0 = pressed
- splitter_en  in  1  splitter fitted
- joy_sel  out  2  splitter slot select
- kbdcol_in  in  5  keyboard columns
- kbdcol_out  out  5  columns with joystick overlay
- vertical_retrace_int_n  in  1  frame interrupt, autofire time base

Behaviour:
- Config regs conf[n], 8 bits each:
  - [2:0] protocol: 0 off, 1 Kempston, 2 SinclairP1, 3 SinclairP2, 4 Cursor, 5 Fuller, 6 OPQA.
  - [3] autofire enable.
  - [5:4] autofire rate r.
  - [7:6] read back as written, unused.
- Config write: zxuno_regwr with zxuno_addr == JOYCONF_BASE+n loads din; takes effect on the next cycle.
- Config reset values: ch0=8'h01, ch1=8'h02, ch2=8'h03, ch3=8'h04, ch4=8'h05.
- db9_in passes through a 2-FF synchroniser before use.
- Splitter FSM, states SELECT, SETTLE, SAMPLE, HOLD:
  - SELECT: drive joy_sel=k, clear cycle counter.
  - SETTLE: wait until counter == SETTLE_CYCLES-1.
  - SAMPLE: one cycle; slotreg[k] <= synced db9.
  - HOLD: wait until counter == SLOT_CYCLES-1, then k <= (k+1) mod NUM_SLOTS and go to SELECT.
  - splitter_en=0: FSM held in SELECT, k=0, joy_sel=0; slotreg[0] loads synced db9 every cycle; other slots forced to 6'h3F.
  - splitter_en dropping mid-slot: immediate return to that mode, no partial sample.
- Reset values: FSM SELECT, k=0, counter=0, slotreg all 6'h3F, joy_sel=0, frame counter 0, edge detector 1.
- Autofire:
  - 5-bit frame counter increments on each rising edge of vertical_retrace_int_n (registered edge detect).
  - Channel gate = counter bit (1+r); period = 2^(2+r) frames.
  - Processed F1 = F1 AND gate when conf[3]=1, else F1.
- Read priority, all combinational from registered state:
  1. zxuno_regrd at JOYCONF_BASE+n: oe=1, dout=conf[n].
  2. I/O read on KEMPSTONADDR1/2: oe=1, dout = OR over Kempston channels of {00,F2,F1,U,D,L,R}; 8'hFF if no channel is Kempston.
  3. I/O read on FULLERADDR: oe=1, dout = AND over Fuller channels of active-low {F1,F2,1,1,R,L,D,U}, base 8'hFF.
  4. Other I/O reads with a[0]=0: keyboard overlay, ANDed active-low into kbdcol_in, one term per matching channel and half-row:
     - SinclairP1, a12: {L,R,D,U,F1}; a8: F2 on bit2.
     - SinclairP2, a11: {F1,U,D,R,L}; a8: F2 on bit1.
     - Cursor, a12: {D,U,R,F2,F1}; a11: L on bit4.
     - OPQA: a13 {L bit1, R bit0}; a10 U bit0; a9 D bit0; a15 {F2 bit2, F1 bit0}.
- Otherwise: oe=0, dout=8'hFF, kbdcol_out=kbdcol_in.
- Several channels on one protocol: contributions merge (OR for Kempston, AND for the others).

Optional Feature:
- JOY_DEBOUNCE_EN defined: each slotreg bit updates only when two consecutive samples of that slot agree; a per-slot previous-sample register is added and reset to 6'h3F.
- Undefined: a single sample updates slotreg directly.

Test Plan:
- Reset, splitter_en=0, db9_in=6'b111110 (R pressed), Kempston read port 0x1F -> dout=8'h01, oe=1; joy_sel=0.
- splitter_en=1, NUM_SLOTS=2, SLOT_CYCLES=100, SETTLE_CYCLES=10: db9_in=6'h3E while joy_sel=0 and 6'h3D while joy_sel=1 -> slotreg0=6'h3E, slotreg1=6'h3D; joy_sel toggles every 100 cycles.
- Write conf[1]=8'h19 (Kempston, autofire, r=1), hold F1 -> Kempston bit4 alternates 4 frames on, 4 frames off.
- conf[1]=2, conf[2]=3, read a=16'hEFFE with slot1 U pressed -> kbdcol_out=5'b11101; a=16'hF7FE with slot2 L pressed -> 5'b11110.
- rst asserted mid-HOLD -> next cycle joy_sel=0, slotregs 6'h3F, conf back to defaults; zxuno read of JOYCONF_BASE+1 -> 8'h02.
- JOY_DEBOUNCE_EN, single-slot glitch on U -> slotreg unchanged; two consecutive samples -> updated.

Source files
------------

// File: rtl/joystick_protocols_mp.sv
// Keyboard joystick plus NUM_SLOTS splitter-multiplexed DB9 joysticks mapped onto
// Kempston/Fuller/Sinclair/Cursor/OPQA. Define JOY_DEBOUNCE_EN for two-sample slot debounce.
`timescale 1ns/1ps
module joystick_protocols_mp #(
  parameter int         NUM_SLOTS     = 2,
  parameter int         SLOT_CYCLES   = 140000,
  parameter int         SETTLE_CYCLES = 64,
  parameter logic [7:0] JOYCONF_BASE  = 8'h06
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] a_i,
  input  logic        iorq_n_i,
  input  logic        rd_n_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o,
  output logic        oe_o,
  input  logic [7:0]  zxuno_addr_i,
  input  logic        zxuno_regrd_i,
  input  logic        zxuno_regwr_i,
  input  logic [4:0]  kbdjoy_in_i,
  input  logic [5:0]  db9_in_i,
  input  logic        splitter_en_i,
  output logic [1:0]  joy_sel_o,
  input  logic [4:0]  kbdcol_in_i,
  output logic [4:0]  kbdcol_out_o,
  input  logic        vertical_retrace_int_n_i
);

  localparam int NCH = NUM_SLOTS + 1;
  localparam int CW  = $clog2(SLOT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [1:0]    K_LAST      = 2'(NUM_SLOTS - 1);

  localparam logic [7:0] KEMPSTON_ADDR1 = 8'h1F;
  localparam logic [7:0] KEMPSTON_ADDR2 = 8'hDF;
  localparam logic [7:0] FULLER_ADDR    = 8'h7F;

  localparam logic [2:0] P_KEMPSTON = 3'd1;
  localparam logic [2:0] P_SINCLAIR1 = 3'd2;
  localparam logic [2:0] P_SINCLAIR2 = 3'd3;
  localparam logic [2:0] P_CURSOR   = 3'd4;
  localparam logic [2:0] P_FULLER   = 3'd5;
  localparam logic [2:0] P_OPQA     = 3'd6;

  typedef enum logic [1:0] {S_SELECT, S_SETTLE, S_SAMPLE, S_HOLD} state_t;

  state_t        state_q;
  logic [1:0]    k_q, k_d, joy_sel_q;
  logic [CW-1:0] cnt_q;
  logic [5:0]    db9_s1_q, db9_s2_q;
  logic [5:0]    slot_q [NUM_SLOTS];
  logic [7:0]    conf_q [NCH];
  logic          vr_q;
  logic [4:0]    frame_q;
  logic [5:0]    joy_c [NCH];
  logic          unused_ok;

  assign unused_ok = &{1'b0, a_i[14]};
  assign k_d       = (k_q == K_LAST) ? 2'd0 : k_q + 2'd1;
  assign joy_sel_o = joy_sel_q;

`ifdef JOY_DEBOUNCE_EN
  logic [5:0] prev_q [NUM_SLOTS];

  // a bit follows the new sample only when it matches the previous one
  function automatic logic [5:0] debounce(input logic [5:0] cur, input logic [5:0] prev,
                                          input logic [5:0] smp);
    return (smp & ~(smp ^ prev)) | (cur & (smp ^ prev));
  endfunction
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NCH; n++) conf_q[n] <= 8'(n + 1);
    end else begin
      for (int n = 0; n < NCH; n++)
        if (zxuno_regwr_i && zxuno_addr_i == JOYCONF_BASE + 8'(n)) conf_q[n] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vr_q    <= 1'b1;
      frame_q <= '0;
    end else begin
      vr_q <= vertical_retrace_int_n_i;
      if (vertical_retrace_int_n_i && !vr_q) frame_q <= frame_q + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db9_s1_q <= 6'h3F;
      db9_s2_q <= 6'h3F;
    end else begin
      db9_s1_q <= db9_in_i;
      db9_s2_q <= db9_s1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_SELECT;
      k_q       <= 2'd0;
      cnt_q     <= '0;
      joy_sel_q <= 2'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= 6'h3F;
`ifdef JOY_DEBOUNCE_EN
        prev_q[i] <= 6'h3F;
`endif
      end
    end else if (!splitter_en_i) begin
      // no splitter: the port is read directly into slot 0 every cycle
      state_q   <= S_SELECT;
      k_q       <= 2'd0;
      cnt_q     <= '0;
      joy_sel_q <= 2'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (i == 0) begin
`ifdef JOY_DEBOUNCE_EN
          prev_q[i] <= db9_s2_q;
          slot_q[i] <= debounce(slot_q[i], prev_q[i], db9_s2_q);
`else
          slot_q[i] <= db9_s2_q;
`endif
        end else begin
          slot_q[i] <= 6'h3F;
        end
      end
    end else begin
      case (state_q)
        S_SELECT: begin
          joy_sel_q <= k_q;
          cnt_q     <= '0;
          state_q   <= S_SETTLE;
        end
        S_SETTLE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SETTLE_LAST) state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (k_q == 2'(i)) begin
`ifdef JOY_DEBOUNCE_EN
              prev_q[i] <= db9_s2_q;
              slot_q[i] <= debounce(slot_q[i], prev_q[i], db9_s2_q);
`else
              slot_q[i] <= db9_s2_q;
`endif
            end
          end
          cnt_q   <= cnt_q + 1'b1;
          state_q <= S_HOLD;
        end
        default: begin
          if (cnt_q == SLOT_LAST) begin
            k_q       <= k_d;
            joy_sel_q <= k_d;
            state_q   <= S_SELECT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // per-channel active-high {F2,F1,U,D,L,R} with autofire applied to F1
  always_comb begin
    joy_c[0] = {1'b0, kbdjoy_in_i};
    for (int s = 0; s < NUM_SLOTS; s++) joy_c[s + 1] = ~slot_q[s];
    for (int n = 0; n < NCH; n++)
      if (conf_q[n][3])
        joy_c[n][4] = joy_c[n][4] & frame_q[{1'b0, conf_q[n][5:4]} + 3'd1];
  end

  logic       kemp_any, conf_hit, io_rd;
  logic [7:0] kemp_or, fuller_and, conf_val;
  logic [4:0] kbd_mask;
  logic [5:0] j;

  always_comb begin
    kemp_any   = 1'b0;
    kemp_or    = 8'h00;
    fuller_and = 8'hFF;
    kbd_mask   = 5'b00000;
    conf_hit   = 1'b0;
    conf_val   = 8'hFF;
    j          = 6'b000000;
    for (int n = 0; n < NCH; n++) begin
      j = joy_c[n];
      if (zxuno_regrd_i && zxuno_addr_i == JOYCONF_BASE + 8'(n)) begin
        conf_hit = 1'b1;
        conf_val = conf_q[n];
      end
      case (conf_q[n][2:0])
        P_KEMPSTON: begin
          kemp_any = 1'b1;
          kemp_or  = kemp_or | {2'b00, j};
        end
        P_FULLER: fuller_and = fuller_and & ~{j[4], j[5], 2'b00, j[0], j[1], j[2], j[3]};
        P_SINCLAIR1: begin
          if (!a_i[12]) kbd_mask = kbd_mask | {j[1], j[0], j[2], j[3], j[4]};
          if (!a_i[8])  kbd_mask = kbd_mask | {2'b00, j[5], 2'b00};
        end
        P_SINCLAIR2: begin
          if (!a_i[11]) kbd_mask = kbd_mask | {j[4], j[3], j[2], j[0], j[1]};
          if (!a_i[8])  kbd_mask = kbd_mask | {3'b000, j[5], 1'b0};
        end
        P_CURSOR: begin
          if (!a_i[12]) kbd_mask = kbd_mask | {j[2], j[3], j[0], j[5], j[4]};
          if (!a_i[11]) kbd_mask = kbd_mask | {j[1], 4'b0000};
        end
        P_OPQA: begin
          if (!a_i[13]) kbd_mask = kbd_mask | {3'b000, j[1], j[0]};
          if (!a_i[10]) kbd_mask = kbd_mask | {4'b0000, j[3]};
          if (!a_i[9])  kbd_mask = kbd_mask | {4'b0000, j[2]};
          if (!a_i[15]) kbd_mask = kbd_mask | {2'b00, j[5], 1'b0, j[4]};
        end
        default: ;
      endcase
    end
  end

  assign io_rd = !iorq_n_i && !rd_n_i;

  always_comb begin
    oe_o         = 1'b0;
    dout_o       = 8'hFF;
    kbdcol_out_o = kbdcol_in_i;
    if (conf_hit) begin
      oe_o   = 1'b1;
      dout_o = conf_val;
    end else if (io_rd && (a_i[7:0] == KEMPSTON_ADDR1 || a_i[7:0] == KEMPSTON_ADDR2)) begin
      oe_o   = 1'b1;
      dout_o = kemp_any ? kemp_or : 8'hFF;
    end else if (io_rd && a_i[7:0] == FULLER_ADDR) begin
      oe_o   = 1'b1;
      dout_o = fuller_and;
    end else if (io_rd && !a_i[0]) begin
      kbdcol_out_o = kbdcol_in_i & ~kbd_mask;
    end
  end

endmodule

// File: tb/tb_joystick_protocols_mp.sv
// Directed bench for joystick_protocols_mp: config regs, protocol reads, splitter, autofire, overlay.
`timescale 1ns/1ps
module tb_joystick_protocols_mp;
  localparam int NS = 2;
  localparam int SC = 100;
  localparam int ST = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        iorq_n, rd_n;
  logic [7:0]  din, dout;
  logic        oe;
  logic [7:0]  zaddr;
  logic        zrd, zwr;
  logic [4:0]  kbdjoy;
  logic [5:0]  db9;
  logic        split_en;
  logic [1:0]  joy_sel;
  logic [4:0]  kcol_in, kcol_out;
  logic        vr;

  logic        use_split;
  logic [5:0]  db9_direct, pat0, pat1;
  int          checks = 0;
  int          errors = 0;
  int          fc;

  always #5 clk = ~clk;

  // external splitter: the selected logical joystick appears on the port
  assign db9 = use_split ? ((joy_sel == 2'd0) ? pat0 : pat1) : db9_direct;

  joystick_protocols_mp #(.NUM_SLOTS(NS), .SLOT_CYCLES(SC), .SETTLE_CYCLES(ST),
                          .JOYCONF_BASE(8'h06)) dut (
    .clk_i(clk), .rst_i(rst), .a_i(a), .iorq_n_i(iorq_n), .rd_n_i(rd_n), .din_i(din),
    .dout_o(dout), .oe_o(oe), .zxuno_addr_i(zaddr), .zxuno_regrd_i(zrd),
    .zxuno_regwr_i(zwr), .kbdjoy_in_i(kbdjoy), .db9_in_i(db9), .splitter_en_i(split_en),
    .joy_sel_o(joy_sel), .kbdcol_in_i(kcol_in), .kbdcol_out_o(kcol_out),
    .vertical_retrace_int_n_i(vr));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic conf_wr(input logic [7:0] ad, input logic [7:0] v);
    zaddr = ad; din = v; zwr = 1'b1;
    tick(1);
    zwr = 1'b0;
  endtask

  task automatic io_on(input logic [15:0] ad);
    a = ad; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
  endtask

  task automatic io_off();
    iorq_n = 1'b1; rd_n = 1'b1; a = 16'hFFFF;
    #1;
  endtask

  task automatic wait_sel(input logic [1:0] v, input int bound, output int n);
    n = 0;
    while (joy_sel !== v && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (joy_sel !== 2'd0) begin errors++; $display("FAIL reset_joy_sel: got %0d want 0", joy_sel); end
    checks++;
    if ({oe, dout} !== {1'b0, 8'hFF}) begin
      errors++; $display("FAIL reset_idle_bus: oe=%b dout=%h want oe=0 dout=ff", oe, dout);
    end
    checks++;
    if (kcol_out !== 5'h1F) begin errors++; $display("FAIL reset_kbdcol: got %b want 11111", kcol_out); end
    for (int n = 0; n < 3; n++) begin
      zaddr = 8'h06 + 8'(n); zrd = 1'b1; #1;
      checks++;
      if ({oe, dout} !== {1'b1, 8'(n + 1)}) begin
        errors++; $display("FAIL reset_conf%0d: oe=%b dout=%h want oe=1 dout=%h", n, oe, dout, 8'(n + 1));
      end
    end
    zaddr = 8'h09; #1;
    checks++;
    if ({oe, dout} !== {1'b0, 8'hFF}) begin
      errors++; $display("FAIL conf_out_of_range: oe=%b dout=%h want oe=0 dout=ff", oe, dout);
    end
    zrd = 1'b0;
  endtask

  task automatic test_kempston_fuller();
    db9_direct = 6'h3E;
    conf_wr(8'h07, 8'h01);
    tick(3);
    io_on(16'h001F);
    checks++;
    if ({oe, dout} !== {1'b1, 8'h01}) begin errors++; $display("FAIL kemp_1f: oe=%b dout=%h want 1/01", oe, dout); end
    io_on(16'h00DF);
    checks++;
    if ({oe, dout} !== {1'b1, 8'h01}) begin errors++; $display("FAIL kemp_df: oe=%b dout=%h want 1/01", oe, dout); end
    kbdjoy = 5'b01000;
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h09) begin errors++; $display("FAIL kemp_merge: got %h want 09", dout); end
    io_off();
    kbdjoy = 5'b00000;
    conf_wr(8'h06, 8'h00);
    conf_wr(8'h07, 8'h00);
    io_on(16'h001F);
    checks++;
    if ({oe, dout} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL kemp_none: oe=%b dout=%h want 1/ff", oe, dout); end
    io_off();
    conf_wr(8'h07, 8'h05);
    io_on(16'h007F);
    checks++;
    if ({oe, dout} !== {1'b1, 8'hF7}) begin errors++; $display("FAIL fuller_r: oe=%b dout=%h want 1/f7", oe, dout); end
    io_off();
    conf_wr(8'h06, 8'h05);
    kbdjoy = 5'b10000;
    io_on(16'h007F);
    checks++;
    if (dout !== 8'h77) begin errors++; $display("FAIL fuller_merge: got %h want 77", dout); end
    io_off();
    kbdjoy = 5'b00000;
    conf_wr(8'h08, 8'hC3);
    zaddr = 8'h08; zrd = 1'b1; #1;
    checks++;
    if (dout !== 8'hC3) begin errors++; $display("FAIL conf_readback: got %h want c3", dout); end
    zrd = 1'b0;
    conf_wr(8'h08, 8'h03);
  endtask

  task automatic test_splitter();
    int n, per;
    conf_wr(8'h06, 8'h00);
    conf_wr(8'h07, 8'h01);
    conf_wr(8'h08, 8'h00);
    pat0 = 6'h3E; pat1 = 6'h3D; use_split = 1'b1;
    split_en = 1'b1;
    tick(50);
    checks++;
    if (joy_sel !== 2'd0) begin errors++; $display("FAIL split_slot0_hold: got %0d want 0", joy_sel); end
    wait_sel(2'd1, 200, n);
    checks++;
    if (n >= 200) begin errors++; $display("FAIL split_to_slot1: timeout after %0d cycles", n); end
    wait_sel(2'd0, 300, per);
    checks++;
    if (per < SC || per > SC + 1) begin
      errors++; $display("FAIL split_period: got %0d cycles want %0d..%0d", per, SC, SC + 1);
    end
    tick(20);
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h01) begin errors++; $display("FAIL slot0_value: got %h want 01", dout); end
    io_off();
    conf_wr(8'h08, 8'h01);
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h03) begin errors++; $display("FAIL slot01_or: got %h want 03", dout); end
    io_off();
    conf_wr(8'h07, 8'h00);
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h02) begin errors++; $display("FAIL slot1_value: got %h want 02", dout); end
    io_off();
    wait_sel(2'd1, 300, n);
    tick(30);
    split_en = 1'b0;
    tick(1);
    checks++;
    if (joy_sel !== 2'd0) begin errors++; $display("FAIL split_drop_sel: got %0d want 0", joy_sel); end
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL split_drop_slot1: got %h want 00", dout); end
    io_off();
    use_split = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    int n;
    db9_direct = 6'h3E; use_split = 1'b1; split_en = 1'b1;
    conf_wr(8'h07, 8'h5A);
    wait_sel(2'd1, 300, n);
    tick(40);
    rst = 1'b1;
    tick(1);
    checks++;
    if (joy_sel !== 2'd0) begin errors++; $display("FAIL rst_hold_sel: got %0d want 0", joy_sel); end
    zaddr = 8'h07; zrd = 1'b1; #1;
    checks++;
    if (dout !== 8'h02) begin errors++; $display("FAIL rst_conf1: got %h want 02", dout); end
    zrd = 1'b0;
    rst = 1'b0;
    conf_wr(8'h06, 8'h01);
    conf_wr(8'h07, 8'h01);
    conf_wr(8'h08, 8'h01);
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL rst_slots: got %h want 00", dout); end
    io_off();
    split_en = 1'b0; use_split = 1'b0;
    fc = 0;
  endtask

  task automatic test_autofire();
    logic [7:0] exp;
    conf_wr(8'h06, 8'h00);
    conf_wr(8'h08, 8'h00);
    conf_wr(8'h07, 8'h19);
    db9_direct = 6'h2F;
    tick(3);
    for (int f = 0; f < 16; f++) begin
      exp = ((fc >> 2) & 1) != 0 ? 8'h10 : 8'h00;
      io_on(16'h001F);
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL autofire_f%0d: got %h want %h", fc, dout, exp); end
      io_off();
      vr = 1'b0; tick(2); vr = 1'b1; tick(2);
      fc++;
    end
    conf_wr(8'h07, 8'h11);
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h10) begin errors++; $display("FAIL autofire_off: got %h want 10", dout); end
    io_off();
    conf_wr(8'h07, 8'h09);
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL autofire_r0_f16: got %h want 00", dout); end
    io_off();
    repeat (2) begin vr = 1'b0; tick(2); vr = 1'b1; tick(2); fc++; end
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h10) begin errors++; $display("FAIL autofire_r0_f18: got %h want 10", dout); end
    io_off();
  endtask

  task automatic test_overlay();
    conf_wr(8'h06, 8'h00);
    conf_wr(8'h08, 8'h00);
    conf_wr(8'h07, 8'h02);
    db9_direct = 6'h37;
    tick(3);
    io_on(16'hEFFE);
    checks++;
    if ({oe, kcol_out} !== {1'b0, 5'b11101}) begin
      errors++; $display("FAIL sinc1_up: oe=%b kbdcol=%b want 0/11101", oe, kcol_out);
    end
    io_on(16'hFEFE);
    checks++;
    if (kcol_out !== 5'b11111) begin errors++; $display("FAIL sinc1_other_row: got %b want 11111", kcol_out); end
    io_on(16'hEFFF);
    checks++;
    if (kcol_out !== 5'b11111) begin errors++; $display("FAIL overlay_a0_high: got %b want 11111", kcol_out); end
    io_off();
    conf_wr(8'h06, 8'h04);
    kbdjoy = 5'b10000;
    io_on(16'hEFFE);
    checks++;
    if (kcol_out !== 5'b11100) begin errors++; $display("FAIL cursor_merge: got %b want 11100", kcol_out); end
    io_off();
    kbdjoy = 5'b00000;
    conf_wr(8'h06, 8'h00);
    conf_wr(8'h07, 8'h03);
    db9_direct = 6'h3D;
    tick(3);
    io_on(16'hF7FE);
    checks++;
    if (kcol_out !== 5'b11110) begin errors++; $display("FAIL sinc2_left: got %b want 11110", kcol_out); end
    io_off();
    conf_wr(8'h07, 8'h06);
    db9_direct = 6'h3E;
    tick(3);
    io_on(16'hDFFE);
    checks++;
    if (kcol_out !== 5'b11110) begin errors++; $display("FAIL opqa_right: got %b want 11110", kcol_out); end
    io_off();
    db9_direct = 6'h2F;
    tick(3);
    io_on(16'h7FFE);
    checks++;
    if (kcol_out !== 5'b11110) begin errors++; $display("FAIL opqa_fire: got %b want 11110", kcol_out); end
    io_off();
  endtask

`ifdef JOY_DEBOUNCE_EN
  task automatic test_debounce();
    conf_wr(8'h06, 8'h00);
    conf_wr(8'h07, 8'h01);
    conf_wr(8'h08, 8'h00);
    db9_direct = 6'h3F; tick(4);
    db9_direct = 6'h37; tick(1);
    db9_direct = 6'h3F; tick(4);
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL debounce_glitch: got %h want 00", dout); end
    io_off();
    db9_direct = 6'h37; tick(5);
    io_on(16'h001F);
    checks++;
    if (dout !== 8'h08) begin errors++; $display("FAIL debounce_stable: got %h want 08", dout); end
    io_off();
  endtask
`endif

  initial begin
    rst = 1'b1; a = 16'hFFFF; iorq_n = 1'b1; rd_n = 1'b1; din = 8'h00;
    zaddr = 8'h00; zrd = 1'b0; zwr = 1'b0; kbdjoy = 5'b00000;
    db9_direct = 6'h3E; pat0 = 6'h3E; pat1 = 6'h3D; use_split = 1'b0;
    split_en = 1'b0; kcol_in = 5'h1F; vr = 1'b1; fc = 0;
    tick(3);
    rst = 1'b0;
    tick(1);
    test_reset();
    test_kempston_fuller();
    test_splitter();
    test_reset_mid_hold();
    test_autofire();
    test_overlay();
`ifdef JOY_DEBOUNCE_EN
    test_debounce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
